// File: rtl/audio_arbiter.sv
// Purpose     : fixed-priority share of the single audio_codec write port between N_SRC sound players.
// Latency     : pop to codec strobe is 2 cycles; one sample per 4 cycles (FETCH, WRITE, strobe, GAP).
// Backpressure: aud_write_ready=0 stalls in WRITE (or FETCH on underrun); src_ready pulses only on an actual pop.
module audio_arbiter #(
    parameter int N_SRC     = 4,
    parameter bit PREEMPT   = 1'b1,
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      src_req,
    input  logic [N_SRC-1:0]      src_valid,
    input  logic [24*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]      src_ready,
    input  logic                  aud_write_ready,
    output logic                  aud_write,
    output logic [23:0]           aud_write_d,
    output logic                  grant_valid,
    output logic [2:0]            grant_id,
    output logic [7:0]            underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        grant_vld_q, grant_vld_d;
    logic [2:0]  grant_id_q, grant_id_d;
    logic [23:0] sample_q, sample_d;
    logic        wr_q, wr_d;
    logic [23:0] wr_dat_q, wr_dat_d;
    logic [7:0]  urun_q, urun_d;

    logic        cand_vld;
    logic [2:0]  cand_id;
    logic        hold_req;
    logic        arb_vld;
    logic [2:0]  arb_id;
    logic        sel_valid;
    logic [23:0] sel_data;

    // Candidate is the lowest-index requester; also look up the current holder's req.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = 3'd0;
        hold_req = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                cand_vld = 1'b1;
                cand_id  = 3'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id_q == 3'(i)) begin
                hold_req = src_req[i];
            end
        end
    end

    // Arbitration result: release a holder that dropped req, optionally preempt by a lower index.
    always_comb begin
        arb_vld = grant_vld_q;
        arb_id  = grant_id_q;
        if (!grant_vld_q || !hold_req) begin
            arb_vld = cand_vld;
            arb_id  = cand_id;
        end else if (PREEMPT && cand_vld && (cand_id < grant_id_q)) begin
            arb_id  = cand_id;
        end
    end

    // Select valid/data of the post-arbitration holder.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = 24'h0;
        for (int i = 0; i < N_SRC; i++) begin
            if (arb_id == 3'(i)) begin
                sel_valid = src_valid[i];
                sel_data  = src_data[i*24 +: 24];
            end
        end
        if (!arb_vld) begin
            sel_valid = 1'b0;
        end
    end

    // Next-state, grant, sample latch, strobe and pop generation.
    always_comb begin
        state_d     = state_q;
        grant_vld_d = grant_vld_q;
        grant_id_d  = grant_id_q;
        sample_d    = sample_q;
        wr_d        = 1'b0;
        wr_dat_d    = wr_dat_q;
        urun_d      = urun_q;
        src_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (cand_vld) begin
                    grant_vld_d = 1'b1;
                    grant_id_d  = cand_id;
                    state_d     = ST_FETCH;
                end else if (IDLE_ZERO && aud_write_ready) begin
                    sample_d = 24'h0;
                    state_d  = ST_WRITE;
                end
            end
            ST_FETCH: begin
                grant_vld_d = arb_vld;
                grant_id_d  = arb_vld ? arb_id : 3'd0;
                if (!arb_vld) begin
                    state_d = ST_IDLE;
                end else if (sel_valid) begin
                    sample_d = sel_data;
                    for (int i = 0; i < N_SRC; i++) begin
                        src_ready[i] = (arb_id == 3'(i));
                    end
                    state_d = ST_WRITE;
                end else if (aud_write_ready) begin
                    // Starved holder: keep the codec fed with silence.
                    sample_d = 24'h0;
                    if (urun_q != 8'hFF) begin
                        urun_d = urun_q + 8'd1;
                    end
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // wr_q marks the strobe cycle; leave only once it has been shown.
                if (wr_q) begin
                    state_d = ST_GAP;
                end else if (aud_write_ready) begin
                    wr_d     = 1'b1;
                    wr_dat_d = sample_q;
                end
            end
            ST_GAP: begin
                state_d = (grant_vld_q || cand_vld) ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any write in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_vld_q <= 1'b0;
            grant_id_q  <= 3'd0;
            sample_q    <= 24'h0;
            wr_q        <= 1'b0;
            wr_dat_q    <= 24'h0;
            urun_q      <= 8'h0;
        end else begin
            state_q     <= state_d;
            grant_vld_q <= grant_vld_d;
            grant_id_q  <= grant_id_d;
            sample_q    <= sample_d;
            wr_q        <= wr_d;
            wr_dat_q    <= wr_dat_d;
            urun_q      <= urun_d;
        end
    end

    assign aud_write    = wr_q;
    assign aud_write_d  = wr_dat_q;
    assign grant_valid  = grant_vld_q;
    assign grant_id     = grant_id_q;
    assign underrun_cnt = urun_q;

endmodule
